// File: rtl/layer_sequencer_pkg.sv
// Shared layer codes, code width and FSM state type for the layer sequencer.
// The layer code is what the weight stores and compute core decode on `cs`.
package layer_sequencer_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_IDLE   = 4'd0;
  localparam logic [CODE_W-1:0] CODE_LAYER0 = 4'd1;
  localparam logic [CODE_W-1:0] CODE_LAYER1 = 4'd2;
  localparam logic [CODE_W-1:0] CODE_LAYER2 = 4'd3;
  localparam logic [CODE_W-1:0] CODE_LAYER3 = 4'd4;
  localparam logic [CODE_W-1:0] CODE_AFFINE = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_W,
    S_RUN,
    S_WAIT_C,
    S_NEXT
  } state_t;

  // Layer k (0-based) is presented to the stores as code k+1.
  function automatic logic [CODE_W-1:0] layer_code(input logic [2:0] layer);
    return CODE_LAYER0 + {1'b0, layer};
  endfunction

endpackage

// File: rtl/layer_sequencer_guard_timer.sv
// Loadable down-counter with zero flag; shared by the post-`cs` guard window
// and the weight-load timeout.
module guard_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/layer_sequencer.sv
// Steps the network through its layers: present `cs`, wait for the weights,
// kick the compute core, wait for it, advance. Optional LOAD_TIMEOUT_EN macro
// adds a weight-load timeout that aborts to idle with a sticky `err`.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = 5,
  parameter int GUARD      = 3,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              w_valid,
  input  logic              core_done,
  output logic [CODE_W-1:0] cs,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 5 || GUARD < 1 || TIMEOUT < 1) begin : g_param_check
    $error("layer_sequencer: parameter out of legal range");
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int TMAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
`else
  localparam int TMAX = GUARD;
`endif
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD - 1);
  localparam logic [2:0]    LAST_LAYER = 3'(NUM_LAYERS - 1);

  state_t            state, state_next;
  logic [CODE_W-1:0] cs_next;
  logic [2:0]        layer, layer_next;
  logic              core_start_next, busy_next, done_next;
  logic              timer_load, timer_dec, timer_zero;
  logic [TW-1:0]     timer_value;

`ifdef LOAD_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT - 1);
  logic err_next;
`endif

  guard_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cs         <= CODE_IDLE;
      layer      <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      cs         <= cs_next;
      layer      <= layer_next;
      core_start <= core_start_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // `cs` only moves when a layer is entered or the run ends, so the stores see
  // a stable code for the whole load and compute of a layer.
  always_comb begin
    state_next      = state;
    cs_next         = cs;
    layer_next      = layer;
    core_start_next = 1'b0;
    busy_next       = busy;
    done_next       = 1'b0;
    timer_load      = 1'b0;
    timer_dec       = 1'b0;
    timer_value     = GUARD_LOAD;
`ifdef LOAD_TIMEOUT_EN
    err_next        = err;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          cs_next    = CODE_LAYER0;
          layer_next = '0;
          busy_next  = 1'b1;
          timer_load = 1'b1;
          state_next = S_LOAD;
        end
      end
      // The previous layer's valid may still be high, so it is not looked at
      // until the guard window has expired.
      S_LOAD: begin
        if (timer_zero) begin
          state_next = S_WAIT_W;
`ifdef LOAD_TIMEOUT_EN
          timer_load  = 1'b1;
          timer_value = TIMEOUT_LOAD;
`endif
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_WAIT_W: begin
        if (w_valid) begin
          state_next = S_RUN;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (timer_zero) begin
          err_next   = 1'b1;
          cs_next    = CODE_IDLE;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else begin
          timer_dec = 1'b1;
        end
`endif
      end
      S_RUN: begin
        core_start_next = 1'b1;
        state_next      = S_WAIT_C;
      end
      S_WAIT_C: begin
        if (core_done) begin
          state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (layer == LAST_LAYER) begin
          cs_next    = CODE_IDLE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else begin
          layer_next = layer + 3'd1;
          cs_next    = layer_code(layer + 3'd1);
          timer_load = 1'b1;
          state_next = S_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  // Sticky until reset; a later start is still accepted with err set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err_next;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a phase-level reference model driven by
// the same inputs is compared with the DUT every cycle, plus literal checks.
module tb_layer_sequencer;

  localparam int GUARD   = 3;
  localparam int NL      = 5;
  localparam int TIMEOUT = 20;

  localparam int PH_IDLE    = 0;
  localparam int PH_LOADING = 1;
  localparam int PH_KICK    = 2;
  localparam int PH_COMPUTE = 3;
  localparam int PH_ADVANCE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       w_valid = 1'b0;
  logic       core_done = 1'b0;
  logic [3:0] cs;
  logic       core_start, busy, done, err;

  logic       start1 = 1'b0;
  logic       core_done1 = 1'b0;
  logic [3:0] cs1;
  logic       core_start1, busy1, done1, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.NUM_LAYERS(NL), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .w_valid    (w_valid),
    .core_done  (core_done),
    .cs         (cs),
    .core_start (core_start),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  layer_sequencer #(.NUM_LAYERS(1), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .w_valid    (1'b1),
    .core_done  (core_done1),
    .cs         (cs1),
    .core_start (core_start1),
    .busy       (busy1),
    .done       (done1),
    .err        (err1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: m_age counts edges since the last cs change; valid is only
  // honoured once more than GUARD edges have passed.
  int         m_phase = PH_IDLE;
  int         m_age = 0;
  int         m_layer = 0;
  logic [3:0] m_cs = 4'd0;
  logic       m_core_start = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    m_core_start = 1'b0;
    m_done       = 1'b0;
    if (rst) begin
      m_phase = PH_IDLE; m_age = 0; m_layer = 0; m_cs = 4'd0;
      m_busy  = 1'b0;    m_err = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE: if (start) begin
          m_phase = PH_LOADING; m_layer = 0; m_cs = 4'd1; m_age = 0; m_busy = 1'b1;
        end
        PH_LOADING: begin
          m_age++;
          if (m_age > GUARD && w_valid) m_phase = PH_KICK;
`ifdef LOAD_TIMEOUT_EN
          else if (m_age == GUARD + TIMEOUT) begin
            m_err = 1'b1; m_cs = 4'd0; m_busy = 1'b0; m_phase = PH_IDLE;
          end
`endif
        end
        PH_KICK: begin
          m_core_start = 1'b1; m_phase = PH_COMPUTE;
        end
        PH_COMPUTE: if (core_done) m_phase = PH_ADVANCE;
        PH_ADVANCE: begin
          if (m_layer == NL - 1) begin
            m_cs = 4'd0; m_done = 1'b1; m_busy = 1'b0; m_phase = PH_IDLE;
          end else begin
            m_layer++; m_cs = 4'(m_layer + 1); m_age = 0; m_phase = PH_LOADING;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  // Compare process plus DUT-side logs used by the literal checks.
  int         cyc = 0;
  int         cs_chg_cyc = 0;
  logic [3:0] prev_cs = 4'bx;
  int         cs_log[$];
  int         lat_log[$];
  int         n_core_start = 0;
  int         n_done = 0;

  always @(negedge clk) begin
    cyc++;
    checkOutput("cs", 32'(cs), 32'(m_cs));
    checkOutput("core_start", 32'(core_start), 32'(m_core_start));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("err", 32'(err), 32'(m_err));
    if (cs !== prev_cs) begin
      cs_log.push_back(int'(cs));
      cs_chg_cyc = cyc;
    end
    if (core_start === 1'b1) begin
      n_core_start++;
      lat_log.push_back(cyc - cs_chg_cyc);
    end
    if (done === 1'b1) n_done++;
    prev_cs = cs;
  end

  // Environment: weight stores and compute core, following the model's view.
  bit         stale = 1'b0, valid_never = 1'b0, spur_load = 1'b0, spur_any = 1'b0;
  int         valid_delay = 290;
  int         done_delay = 50;
  int         since_cs = 0;
  int         done_cnt = 0;
  logic [3:0] env_prev_cs = 4'd0;

  always @(negedge clk) begin
    if (m_cs != env_prev_cs) since_cs = 0;
    else since_cs++;
    env_prev_cs = m_cs;
    w_valid = stale || (!valid_never && m_cs != 4'd0 && since_cs >= valid_delay);
    core_done = 1'b0;
    if (m_core_start) done_cnt = done_delay;
    else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) core_done = 1'b1;
    end
    if (spur_load && m_phase == PH_LOADING && $urandom_range(0, 3) == 0) core_done = 1'b1;
    if (spur_any && $urandom_range(0, 15) == 0) core_done = 1'b1;
  end

  task automatic clearLogs();
    cs_log.delete();
    lat_log.delete();
    n_core_start = 0;
    n_done = 0;
  endtask

  // One inference: pulse start, then wait (bounded) for the model to go idle,
  // optionally sprinkling start pulses while busy.
  task automatic applyStimulus(input bit noise, input int max_cycles);
    int n;
    @(posedge clk); #1;
    clearLogs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (m_phase != PH_IDLE && n < max_cycles) begin
      @(negedge clk);
      start = noise && ($urandom_range(0, 5) == 0);
      n++;
    end
    start = 1'b0;
    checkOutput("run_complete", 32'(m_phase), 32'(PH_IDLE));
  endtask

  task automatic checkFullRun(input string tag);
    int exp_cs[6] = '{1, 2, 3, 4, 5, 0};
    @(posedge clk); #1;
    checkOutput({tag, "_cs_changes"}, 32'(cs_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("%s_cs_seq%0d", tag, i),
                  (i < cs_log.size()) ? 32'(cs_log[i]) : 32'hFFFF_FFFF, 32'(exp_cs[i]));
    checkOutput({tag, "_core_starts"}, 32'(n_core_start), 32'd5);
    checkOutput({tag, "_dones"}, 32'(n_done), 32'd1);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs", 32'(cs), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_core_start", 32'(core_start), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] full run with slow weight loads");
    valid_delay = 290; done_delay = 50;
    applyStimulus(1'b0, 4000);
    checkFullRun("full");

    $display("[TB] stale valid held high across layers");
    stale = 1'b1; done_delay = 5;
    applyStimulus(1'b0, 500);
    checkFullRun("stale");
    // cs change -> valid honoured GUARD+1 edges later -> registered pulse one edge after
    checkOutput("stale_latency_layer0", (lat_log.size() > 0) ? 32'(lat_log[0]) : 32'd0, 32'd5);
    checkOutput("stale_latency_layer1", (lat_log.size() > 1) ? 32'(lat_log[1]) : 32'd0, 32'd5);
    stale = 1'b0;

    $display("[TB] spurious core_done while loading and start while busy");
    valid_delay = 12; done_delay = 8; spur_load = 1'b1;
    applyStimulus(1'b1, 1000);
    checkFullRun("spurious");
    spur_load = 1'b0;

    $display("[TB] reset during layer 2 compute");
    valid_delay = 6; done_delay = 20;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(m_cs == 4'd3 && m_phase == PH_COMPUTE) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_layer2_compute", 32'(cs), 32'd3);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("midreset_cs", 32'(cs), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_core_start", 32'(core_start), 32'd0);
    repeat (25) @(negedge clk);
    applyStimulus(1'b0, 1000);
    checkFullRun("restart");

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      valid_delay = $urandom_range(0, 10);
      done_delay  = $urandom_range(1, 6);
      stale       = ($urandom_range(0, 3) == 0);
      spur_any    = ($urandom_range(0, 1) == 1);
      applyStimulus(1'b1, 1500);
    end
    stale = 1'b0; spur_any = 1'b0;
    repeat (10) @(negedge clk);

`ifdef LOAD_TIMEOUT_EN
    $display("[TB] weight load timeout");
    valid_never = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("to_cs_layer0", 32'(cs), 32'd1);
    repeat (22) @(negedge clk);
    checkOutput("to_err_before", 32'(err), 32'd0);
    checkOutput("to_cs_before", 32'(cs), 32'd1);
    @(negedge clk);
    checkOutput("to_err", 32'(err), 32'd1);
    checkOutput("to_cs", 32'(cs), 32'd0);
    checkOutput("to_busy", 32'(busy), 32'd0);
    checkOutput("to_no_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("to_restart_cs", 32'(cs), 32'd1);
    checkOutput("to_err_sticky", 32'(err), 32'd1);
    repeat (30) @(negedge clk);
    valid_never = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("to_err_cleared", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
`endif

    $display("[TB] single-layer instance");
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    checkOutput("nl1_cs_layer0", 32'(cs1), 32'd1);
    checkOutput("nl1_busy", 32'(busy1), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("nl1_no_early_kick", 32'(core_start1), 32'd0);
    @(negedge clk);
    checkOutput("nl1_core_start", 32'(core_start1), 32'd1);
    core_done1 = 1'b1;
    @(negedge clk); core_done1 = 1'b0;
    checkOutput("nl1_core_start_once", 32'(core_start1), 32'd0);
    checkOutput("nl1_done_not_yet", 32'(done1), 32'd0);
    @(negedge clk);
    checkOutput("nl1_done", 32'(done1), 32'd1);
    checkOutput("nl1_cs_idle", 32'(cs1), 32'd0);
    checkOutput("nl1_busy_low", 32'(busy1), 32'd0);
    @(negedge clk);
    checkOutput("nl1_done_pulse", 32'(done1), 32'd0);
    checkOutput("nl1_err", 32'(err1), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Top-level controller that steps the network through LAYER0..LAYER3 then AFFINE. It drives the 4-bit `cs` code consumed by the weight stores and waits for their `valid` (all 288 weights loaded). It then pulses `core_start` to the compute core, waits for `core_done`, and advances to the next layer. It sits between the host start/done handshake and the weight_store/compute datapath.

Parameters:
NUM_LAYERS, 5, layers sequenced (LAYER0..LAYER3, AFFINE); legal 1..5
GUARD, 3, cycles `w_valid` is ignored after every `cs` change (covers store init latency of 2 cycles plus 1 margin)
TIMEOUT, 1023, cycles allowed in WAIT_W before error (used only with LOAD_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a full inference; sampled only in IDLE
w_valid  in  1  weight store valid; level signal
core_done  in  1  one-cycle pulse from compute core at layer end
cs  out  4  current layer code to weight stores/core
core_start  out  1  one-cycle pulse to compute core
busy  out  1  high from leaving IDLE until return to IDLE
done  out  1  one-cycle pulse when AFFINE completes
err  out  1  sticky load-timeout flag (tied 0 without LOAD_TIMEOUT_EN)

Behaviour:
- Layer codes come from the shared header: IDLE=4'd0, LAYER0=4'd1, LAYER1=4'd2, LAYER2=4'd3, LAYER3=4'd4, AFFINE=4'd5. Layer k (0-based) maps to code k+1.
- Reset (sync, active-high, overrides everything): state=S_IDLE, cs=IDLE, core_start=0, busy=0, done=0, err=0, layer counter=0, guard counter=0.
- FSM states: S_IDLE, S_LOAD, S_WAIT_W, S_RUN, S_WAIT_C, S_NEXT.
- S_IDLE: if start=1, then cs<=LAYER0, layer=0, guard=GUARD-1, busy<=1, go to S_LOAD. Otherwise hold cs=IDLE.
- S_LOAD: decrement guard; when guard reaches 0, go to S_WAIT_W. w_valid is ignored here, because the stale valid from the previous layer is still high.
- S_WAIT_W: on w_valid=1, go to S_RUN. Minimum latency from a cs change to S_RUN is GUARD+1 cycles.
- S_RUN: core_start<=1 for exactly one cycle, then go to S_WAIT_C.
- S_WAIT_C: on core_done=1, go to S_NEXT. A core_done seen in any other state is ignored.
- S_NEXT:
  - If layer==NUM_LAYERS-1: cs<=IDLE, done<=1 for one cycle, busy<=0, go to S_IDLE.
  - Else: layer+1, cs<=layer+2 (code), guard=GUARD-1, go to S_LOAD.
- `cs` changes only on S_IDLE→S_LOAD and on S_NEXT, so it is stable for the full load and compute of a layer.
- start while busy is ignored; no queuing.
- done and start in the same cycle: done is issued and the FSM enters S_IDLE; that start is not accepted (the FSM was not in S_IDLE when it was sampled).
- Reset mid-layer: immediate return to IDLE; cs=IDLE forces the weight stores to re-init on the next start.
- Counters: layer is 3 bits; guard is clog2(GUARD+1) bits; no wrap is possible.

Optional Feature:
LOAD_TIMEOUT_EN:
- Defined: a counter runs in S_WAIT_W. If w_valid is not seen within TIMEOUT cycles, err<=1 (sticky until rst), cs<=IDLE, busy<=0, no done, go to S_IDLE. A subsequent start is still accepted while err stays set.
- Undefined: no counter; S_WAIT_W waits indefinitely; err is constant 0.

Decomposition:
- Shared header `state_layer_data.v`: the layer code defines (IDLE, LAYER0..LAYER3, AFFINE) and the 4-bit code width.
- Local defines for the FSM state encoding.
- One sub-module: `guard_timer`, a loadable down-counter with zero flag, reused for the GUARD count and the TIMEOUT count.

Test Plan:
- Full run: rst, start pulse; w_valid rises 290 cycles after each cs change; core_done 50 cycles after each core_start → cs sequence 1,2,3,4,5,0; exactly 5 core_start pulses; one done pulse; busy low afterwards.
- Stale valid: w_valid held at 1 continuously across the LAYER0→LAYER1 change → no core_start for LAYER1 earlier than GUARD+1=4 cycles after the cs change.
- Spurious inputs: core_done pulsed during S_LOAD and start pulsed during S_WAIT_C → both ignored; cs and layer unchanged.
- Reset mid-run: rst asserted for 1 cycle during LAYER2 S_WAIT_C → next cycle cs=0, busy=0, core_start=0; new start restarts at LAYER0.
- Timeout (LOAD_TIMEOUT_EN, TIMEOUT=20): w_valid never asserted → err=1 and cs=0 exactly 20 cycles into S_WAIT_W; no done; err held until rst.
- NUM_LAYERS=1: start → cs=1, one core_start, done after core_done, cs=0.
